// File: rtl/vmc.sv
// vmc: three-item vending machine controller with greedy change return
module vmc (
  input  logic       CLOCK,
  input  logic       nRESET,
  input  logic       START,
  input  logic       OK,
  input  logic       CANCEL,
  input  logic       SELECT,
  input  logic       COIN_1,
  input  logic       COIN_5,
  input  logic       COIN_10,
  output logic [2:0] ITEM,
  output logic       DISPENSE,
  output logic       C1,
  output logic       C5,
  output logic       C10
);
  typedef enum logic [2:0] {IDLE, SEL, PAY, DISP, CHG} state_t;
  state_t     state, state_n;
  logic [6:0] credit, credit_n, price, price_n;
  logic [2:0] item_n;
  logic       disp_n, c1_n, c5_n, c10_n;
  logic [4:0] coins;
  logic [7:0] total;
  assign coins = (COIN_10 ? 5'd10 : 5'd0) + (COIN_5 ? 5'd5 : 5'd0) + (COIN_1 ? 5'd1 : 5'd0);
  assign total = {1'b0, credit} + {3'b0, coins};
  // state, credit and registered outputs update on the falling edge
  always_ff @(negedge CLOCK or posedge nRESET)
    if (nRESET) begin
      state    <= IDLE;
      credit   <= '0;
      price    <= '0;
      ITEM     <= '0;
      DISPENSE <= 1'b0;
      C1       <= 1'b0;
      C5       <= 1'b0;
      C10      <= 1'b0;
    end else begin
      state    <= state_n;
      credit   <= credit_n;
      price    <= price_n;
      ITEM     <= item_n;
      DISPENSE <= disp_n;
      C1       <= c1_n;
      C5       <= c5_n;
      C10      <= c10_n;
    end
  // next-state, credit bookkeeping and strobe generation
  always_comb begin
    state_n  = state;
    credit_n = credit;
    price_n  = price;
    item_n   = ITEM;
    disp_n   = 1'b0;
    c1_n     = 1'b0;
    c5_n     = 1'b0;
    c10_n    = 1'b0;
    case (state)
      IDLE: begin
        item_n  = START ? 3'b001 : 3'b000;
        state_n = START ? SEL : IDLE;
      end
      SEL:
        if (CANCEL) begin
          state_n = IDLE;
          item_n  = 3'b000;
        end else if (OK) begin
          state_n  = PAY;
          credit_n = '0;
          price_n  = ITEM[2] ? 7'd12 : ITEM[1] ? 7'd5 : 7'd3;
        end else if (SELECT)
          item_n = {ITEM[1:0], ITEM[2]};
      PAY:
        if (CANCEL)
          state_n = CHG;
        else if (OK) begin
          if (credit >= price) begin
            state_n  = DISP;
            credit_n = credit - price;
            disp_n   = 1'b1;
          end
        end else if (!SELECT && total <= 8'd99)
          credit_n = total[6:0];
      DISP: begin
        state_n = credit != '0 ? CHG : IDLE;
        item_n  = credit != '0 ? ITEM : 3'b000;
      end
      CHG: begin
        c10_n    = credit >= 7'd10;
        c5_n     = !c10_n && credit >= 7'd5;
        c1_n     = !c10_n && !c5_n && credit != '0;
        credit_n = credit - (c10_n ? 7'd10 : c5_n ? 7'd5 : c1_n ? 7'd1 : 7'd0);
        state_n  = credit_n == '0 ? IDLE : CHG;
        item_n   = credit_n == '0 ? 3'b000 : ITEM;
      end
      default: begin
        state_n = IDLE;
        item_n  = 3'b000;
      end
    endcase
  end
endmodule

// File: tb/tb_vmc.sv
// tb_vmc: directed-step bench for the vending machine controller
module tb_vmc;
  logic       CLOCK = 1'b0, nRESET = 1'b1;
  logic       START = 0, OK = 0, CANCEL = 0, SELECT = 0, COIN_1 = 0, COIN_5 = 0, COIN_10 = 0;
  logic [2:0] ITEM;
  logic       DISPENSE, C1, C5, C10;
  int         checks = 0, fails = 0;
  int         nd = 0, n1 = 0, n5 = 0, n10 = 0, multi = 0;
  int         sd, s1, s5, s10;
  localparam logic [6:0] Z = 7'b0000000, ST = 7'b1000000, OKK = 7'b0100000, CAN = 7'b0010000,
                         SL = 7'b0001000, K1 = 7'b0000100, K5 = 7'b0000010, K10 = 7'b0000001;
  vmc dut (.CLOCK(CLOCK), .nRESET(nRESET), .START(START), .OK(OK), .CANCEL(CANCEL), .SELECT(SELECT),
           .COIN_1(COIN_1), .COIN_5(COIN_5), .COIN_10(COIN_10), .ITEM(ITEM), .DISPENSE(DISPENSE),
           .C1(C1), .C5(C5), .C10(C10));
  always #10 CLOCK = ~CLOCK;
  // strobe tallies sampled on the rising edge, midway between state updates
  always @(posedge CLOCK) begin
    nd  <= nd + int'(DISPENSE);
    n1  <= n1 + int'(C1);
    n5  <= n5 + int'(C5);
    n10 <= n10 + int'(C10);
    if (int'(C1) + int'(C5) + int'(C10) > 1) multi <= multi + 1;
  end
  task automatic step(input logic [6:0] v);
    @(posedge CLOCK);
    #1;
    {START, OK, CANCEL, SELECT, COIN_1, COIN_5, COIN_10} = v;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(Z);
  endtask
  task automatic seq(input logic [6:0] v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic snap;
    sd = nd; s1 = n1; s5 = n5; s10 = n10;
  endtask
  task automatic tally(input string tag, input int d, input int c1, input int c5, input int c10);
    chk({tag, " dispense"}, nd - sd, d);
    chk({tag, " c1"}, n1 - s1, c1);
    chk({tag, " c5"}, n5 - s5, c5);
    chk({tag, " c10"}, n10 - s10, c10);
    chk({tag, " item end"}, int'(ITEM), 0);
  endtask
  initial begin
    #30 nRESET = 1'b0;
    chk("reset item", int'(ITEM), 0);
    chk("reset strobes", int'({DISPENSE, C1, C5, C10}), 0);
    snap;
    step(ST); step(Z);
    chk("t1 start item", int'(ITEM), 1);
    step(OKK); seq(K1, 3); step(Z);
    chk("t1 pay item", int'(ITEM), 1);
    step(OKK); step(Z);
    chk("t1 dispense high", int'(DISPENSE), 1);
    step(Z);
    chk("t1 dispense one cycle", int'(DISPENSE), 0);
    idle(4);
    tally("t1", 1, 0, 0, 0);
    snap;
    step(ST); step(SL); step(OKK); step(K10); step(Z);
    chk("t2 item", int'(ITEM), 2);
    step(OKK); idle(6);
    tally("t2", 1, 0, 1, 0);
    snap;
    step(ST); seq(SL, 2); step(OKK); step(K10); step(K1); step(Z);
    chk("t3 item", int'(ITEM), 4);
    @(posedge CLOCK);
    #5 CANCEL = 1'b1;
    #30 CANCEL = 1'b0;
    idle(6);
    tally("t3", 0, 1, 0, 1);
    snap;
    step(ST); seq(SL, 2); step(OKK); step(K5); step(OKK); idle(3);
    chk("t4 underpay no dispense", nd - sd, 0);
    chk("t4 underpay item held", int'(ITEM), 4);
    step(K10); step(OKK); idle(8);
    tally("t4", 1, 3, 0, 0);
    snap;
    step(ST); seq(SL, 3); step(Z);
    chk("t5 select wrap", int'(ITEM), 1);
    step(OKK); seq(K10, 9); step(K5); seq(K1, 4); step(K10); step(K1); step(CAN); idle(20);
    tally("t5 cap", 0, 4, 1, 9);
    snap;
    step(ST); step(OKK); step(K1 | K5 | K10); step(OKK); idle(8);
    tally("t6 summed coins", 1, 3, 0, 1);
    step(ST); step(Z);
    chk("t7 item before reset", int'(ITEM), 1);
    #5 nRESET = 1'b1;
    #1;
    chk("t7 async reset item", int'(ITEM), 0);
    #4 nRESET = 1'b0;
    snap;
    step(OKK); step(K10); idle(3);
    chk("t7 idle after reset", int'(ITEM), 0);
    tally("t7", 0, 0, 0, 0);
    chk("one strobe per cycle", multi, 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
